// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine feeding the framebuffer RAM write port: clips a command
// to the screen and streams one word write per clock, row by row.
module fb_rect_fill #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240,
  parameter int ADDR_W    = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [31:0]       cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic              ram_clken
);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t             state;
  logic [8:0]         x_q, w_q, cw_q, col;
  logic [7:0]         y_q, h_q, ch_q, row;
  logic [ADDR_W-1:0]  row_base, addr_q, base_n;
  logic [31:0]        color_q;
  logic               wr_q, done_q;
  logic [8:0]         cw_n;
  logic [7:0]         ch_n;
  logic               empty, last_col, last_row;

  // Extent from start to min(start+len, limit); sums fit in 10 bits.
  function automatic logic [9:0] clip_extent(input logic [9:0] start,
                                             input logic [9:0] len,
                                             input logic [9:0] limit);
    logic [9:0] stop;
    stop = start + len;
    if (stop > limit) stop = limit;
    return stop - start;
  endfunction

  always_comb begin
    cw_n     = 9'(clip_extent({1'b0, x_q}, {1'b0, w_q}, 10'(FB_WIDTH)));
    ch_n     = 8'(clip_extent({2'b0, y_q}, {2'b0, h_q}, 10'(FB_HEIGHT)));
    empty    = (x_q >= 9'(FB_WIDTH)) || (y_q >= 8'(FB_HEIGHT)) ||
               (w_q == 9'd0) || (h_q == 8'd0);
    base_n   = ADDR_W'(y_q) * ADDR_W'(FB_WIDTH);
    last_col = (col == cw_q - 9'd1);
    last_row = (row == ch_q - 8'd1);
  end

  // Control: state, write strobe, done pulse, address and colour
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state   <= SETUP;
            color_q <= cmd_color;
          end
        end
        SETUP: begin
          if (empty) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state  <= FILL;
            wr_q   <= 1'b1;
            addr_q <= base_n + ADDR_W'(x_q);
          end
        end
        FILL: begin
          if (last_col && last_row) begin
            state  <= DONE;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
          end else if (last_col) begin
            addr_q <= row_base + ADDR_W'(FB_WIDTH) + ADDR_W'(x_q);
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: latched command, clipped extents and raster counters
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          x_q <= cmd_x;
          y_q <= cmd_y;
          w_q <= cmd_w;
          h_q <= cmd_h;
        end
      end
      SETUP: begin
        cw_q     <= cw_n;
        ch_q     <= ch_n;
        row_base <= base_n;
        col      <= 9'd0;
        row      <= 8'd0;
      end
      FILL: begin
        if (last_col) begin
          col      <= 9'd0;
          row      <= row + 8'd1;
          row_base <= row_base + ADDR_W'(FB_WIDTH);
        end else begin
          col <= col + 9'd1;
        end
      end
      default: ;
    endcase
  end

  // Reset masks the strobes in the cycle it is sampled so an abandoned fill
  // commits nothing further to the RAM.
  assign busy           = (state != IDLE);
  assign cmd_ready      = ~busy;
  assign done           = done_q & ~reset;
  assign ram_write      = wr_q & ~reset;
  assign ram_chipselect = wr_q & ~reset;
  assign ram_address    = addr_q;
  assign ram_writedata  = color_q;
  assign ram_byteenable = 4'hF;
  assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed and random rectangles checked against a
// clipped-raster reference list of expected word addresses.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [8:0]  cmd_x = '0, cmd_w = '0;
  logic [7:0]  cmd_y = '0, cmd_h = '0;
  logic [31:0] cmd_color = '0;
  logic        cmd_ready, busy, done;
  logic [16:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  fb_rect_fill dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .busy(busy), .done(done),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference raster: every on-screen pixel of the rectangle, row-major.
  task automatic build_exp(input int x, input int y, input int w, input int h);
    exp_q.delete();
    for (int r = y; r < y + h && r < 240; r++)
      for (int c = x; c < x + w && c < 320; c++)
        exp_q.push_back(r * 320 + c);
  endtask

  task automatic scramble();
    cmd_x = 9'($urandom); cmd_y = 8'($urandom);
    cmd_w = 9'($urandom); cmd_h = 8'($urandom);
    cmd_color = $urandom;
  endtask

  task automatic drive(input int x, input int y, input int w, input int h, input logic [31:0] c);
    cmd_x = 9'(x); cmd_y = 8'(y); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = c;
  endtask

  // Present a command in IDLE; returns 1 ns after the accepting edge.
  task automatic start_cmd(input int x, input int y, input int w, input int h, input logic [31:0] c);
    @(negedge clk);
    drive(x, y, w, h, c);
    cmd_valid = 1'b1;
    check_eq("rdy_idle", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    scramble();
  endtask

  // Follows the command from SETUP to its done pulse; ends at the DONE negedge.
  task automatic observe(input int x, input int y, input int w, input int h, input logic [31:0] c);
    int n, wr, done_i;
    build_exp(x, y, w, h);
    n = exp_q.size();
    wr = 0;
    done_i = 0;
    for (int i = 1; i <= n + 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check_eq("setup_busy", busy, 1'b1);
        check_eq("setup_rdy", cmd_ready, 1'b0);
      end
      if (ram_write) begin
        if (wr < n) check_eq("addr", ram_address, exp_q[wr]);
        else check_eq("extra_write", 1'b1, 1'b0);
        check_eq("data", ram_writedata, c);
        check_eq("cs", ram_chipselect, 1'b1);
        check_eq("be", ram_byteenable, 4'hF);
        check_eq("no_gap", i, wr + 2);
        wr++;
      end
      if (done) begin
        done_i = i;
        check_eq("done_rdy", cmd_ready, 1'b0);
        break;
      end
    end
    check_eq("write_count", wr, n);
    check_eq("done_cycle", done_i, n + 2);
  endtask

  task automatic single(input int x, input int y, input int w, input int h, input logic [31:0] c);
    start_cmd(x, y, w, h, c);
    observe(x, y, w, h, c);
    @(negedge clk);
    check_eq("rdy_back", cmd_ready, 1'b1);
    check_eq("done_low", done, 1'b0);
  endtask

  initial begin
    int wr, extra;
    int ax, ay, aw, ah, bx, by, bw, bh;
    logic [31:0] ac, bc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_write", ram_write, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_rdy", cmd_ready, 1'b1);
    check_eq("rst_busy2", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_cs", ram_chipselect, 1'b0);
    check_eq("rst_addr", ram_address, 17'd0);
    check_eq("rst_wdata", ram_writedata, 32'd0);
    check_eq("rst_be", ram_byteenable, 4'hF);
    check_eq("rst_clken", ram_clken, 1'b1);

    single(0, 0, 2, 2, 32'hAABBCCDD);
    single(318, 239, 5, 3, 32'h12345678);
    single(320, 0, 4, 4, 32'h1);
    single(0, 240, 1, 1, 32'h2);
    single(10, 10, 0, 5, 32'h3);
    single(10, 10, 5, 0, 32'h4);
    single(0, 0, 320, 240, 32'h0);

    for (int t = 0; t < 10; t++)
      single($urandom_range(0, 340), $urandom_range(0, 250),
             $urandom_range(0, 32), $urandom_range(0, 16), $urandom);

    // Reset on the 5th FILL cycle of a 10x10 fill
    start_cmd(0, 0, 10, 10, 32'hCAFEF00D);
    wr = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (ram_write) begin
        check_eq("rst_fill_addr", ram_address, wr);
        wr++;
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_fill_nowr", ram_write, 1'b0);
    check_eq("rst_fill_nodone", done, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_fill_wcount", wr, 4);
    check_eq("rst_after_wr", ram_write, 1'b0);
    check_eq("rst_after_busy", busy, 1'b0);
    check_eq("rst_after_rdy", cmd_ready, 1'b1);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ram_write || done) extra++;
    end
    check_eq("rst_quiet", extra, 0);

    // Back-to-back with cmd_valid held high; B sits on the bus during A's fill
    ax = $urandom_range(0, 300); ay = $urandom_range(0, 230);
    aw = $urandom_range(1, 12);  ah = $urandom_range(1, 6); ac = $urandom;
    bx = $urandom_range(0, 300); by = $urandom_range(0, 230);
    bw = $urandom_range(1, 12);  bh = $urandom_range(1, 6); bc = $urandom;
    @(negedge clk);
    drive(ax, ay, aw, ah, ac);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 drive(bx, by, bw, bh, bc);
    observe(ax, ay, aw, ah, ac);
    @(negedge clk);
    check_eq("b2b_rdy", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    scramble();
    observe(bx, by, bw, bh, bc);
    @(negedge clk);
    check_eq("b2b_end_rdy", cmd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
